colparity_ctrl: RTL and testbench
=================================

Name: colparity_ctrl

Overview:
- Sequencer for the ColParity (theta column-parity) datapath over a 5x5xSLICES state held slice-per-word in a state RAM.
- Issues slice reads and result writes, and drives the load strobe of the 5-bit previous-parity register so each slice z sees the parity of slice z-1.
- Handles the z=0 wrap-around by preloading the parity of slice SLICES-1 before the main sweep.
- Sits between the top-level start/done interface and the existing datapath: state RAM, parity XOR tree, previous-parity register, result RAM.

Parameters:
- SLICES, 64, number of z-slices processed per run; must be >= 2.
- ADDR_W, 6, slice address width; must satisfy 2^ADDR_W >= SLICES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted through the DRAIN cycle.
- done  output  1  one-cycle pulse in the cycle after the last write.
- rd_en  output  1  state-RAM read enable; RAM data is valid exactly 1 cycle later.
- rd_addr  output  ADDR_W  slice address for the read.
- prev_ld  output  1  load strobe for the previous-parity register (captures the parity of the slice whose data is currently valid).
- wr_en  output  1  result-RAM write enable.
- wr_addr  output  ADDR_W  slice address for the write.

Behaviour:
- Reset (async, any state): state <= IDLE; z counter <= 0; write-valid flag <= 0. All outputs read 0: busy, done, rd_en, prev_ld, wr_en, rd_addr, wr_addr. No partial-run recovery; a reset mid-run abandons the run, and the next run requires a fresh start.
- States: IDLE, PRE, RUN, DRAIN, DONE.
- IDLE: all strobes 0. start=1 -> PRE.
- PRE (1 cycle):
  - rd_en=1, rd_addr=SLICES-1, busy=1.
  - Next state: RUN with z=0.
- RUN (SLICES cycles, z = 0..SLICES-1):
  - rd_en=1, rd_addr=z, prev_ld=1.
  - wr_en=1 with wr_addr=z-1, but only when z>0.
  - z increments each cycle; after z=SLICES-1 -> DRAIN.
- DRAIN (1 cycle): rd_en=0, prev_ld=1, wr_en=1, wr_addr=SLICES-1 -> DONE.
- DONE (1 cycle): done=1, busy=0, all strobes 0 -> IDLE.
- Timing for SLICES=64, with start accepted at edge t0:
  - PRE at t1, RUN at t2..t65, DRAIN at t66, DONE at t67.
  - Total: 67 cycles from start to done.
- prev_ld and wr_en coincide on the same edge: the write uses the register's old contents (slice z-1 parity), and the register then updates to slice z. In the first RUN cycle, prev_ld captures the parity of slice SLICES-1 with no write.
- Strobe counts per run:
  - rd_en asserted SLICES+1 times; slice SLICES-1 is read twice (preload and sweep).
  - prev_ld asserted SLICES+1 times.
  - wr_en asserted exactly SLICES times, addresses 0..SLICES-1 in order, each once.
- Address rules:
  - The z counter is ADDR_W+1 bits wide internally, so the terminal compare never aliases when SLICES = 2^ADDR_W.
  - Output addresses are the low ADDR_W bits.
- start while busy or in DONE: ignored, with no queuing. A start in the DONE cycle is dropped; it must be reasserted in IDLE.
- Registered outputs: all outputs come directly from flops or from a decode of the state register. No combinational path from start to any output.

Decomposition:
- Shared package colparity_pkg:
  - state encoding constants (S_IDLE, S_PRE, S_RUN, S_DRAIN, S_DONE, 3-bit);
  - default SLICES and ADDR_W;
  - RAM read latency constant (=1).
- One natural sub-module, colparity_slice_cnt: a loadable up-counter with clear, enable and terminal-count flag, sized ADDR_W+1.
- FSM and output decode stay in colparity_ctrl.

Test Plan:
- Reset then idle, no start for 20 cycles -> all outputs 0, state IDLE.
- start pulse, SLICES=64 -> exact per-cycle trace:
  - rd_addr 63 at t1, then 0..63 at t2..t65;
  - wr_addr 0..63 at t3..t66;
  - prev_ld high t2..t66;
  - done high only at t67.
- SLICES=4, ADDR_W=2 (full address range) -> read order 3,0,1,2,3; write order 0,1,2,3; done at t7; no address alias.
- start held high continuously -> back-to-back runs each 67 cycles plus one IDLE cycle between runs; extra start cycles are ignored.
- rst asserted mid-RUN (z=30), asynchronously between edges -> outputs drop to 0 immediately. After release with no start, nothing fires. A new start produces a full clean run from slice 63 preload.
- With a golden datapath model attached, random 1600-bit state -> result RAM equals the reference theta column-parity D term for all 64 slices, including z=0 using slice 63.

Source files
------------

// File: rtl/colparity_pkg.sv
// Shared types and constants for the ColParity (theta column-parity) sequencer.
package colparity_pkg;

  localparam int unsigned SLICES_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned RD_LAT     = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic rd_en;
    logic prev_ld;
    logic wr_en;
  } strobe_t;

endpackage

// File: rtl/colparity_slice_cnt.sv
// Loadable slice up-counter with clear, enable and terminal-count flag.
module colparity_slice_cnt #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned LAST  = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign last_c = (cnt == WIDTH'(LAST));

endmodule

// File: rtl/colparity_ctrl.sv
// Sequencer for the theta column-parity datapath: wrap-around preload, slice sweep, drain.
module colparity_ctrl
  import colparity_pkg::*;
#(
  parameter int unsigned SLICES = SLICES_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              prev_ld,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int unsigned        CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SLICES - 1);

  state_t            state;
  state_t            state_nx;
  strobe_t           str_nx;
  logic [ADDR_W-1:0] rd_addr_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [CNT_W-1:0]  z;
  logic              z_last_c;
  logic              cnt_clr;
  logic              cnt_ld;
  logic              cnt_en;

  colparity_slice_cnt #(
    .WIDTH (CNT_W),
    .LAST  (SLICES - 1)
  ) u_slice_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .ld     (cnt_ld),
    .ld_val (CNT_W'(0)),
    .en     (cnt_en),
    .cnt    (z),
    .last_c (z_last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Outputs are computed for the upcoming state so they leave flops aligned with it.
  always_comb begin
    state_nx   = state;
    str_nx     = '0;
    rd_addr_nx = '0;
    wr_addr_nx = '0;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx     = S_PRE;
          str_nx.busy  = 1'b1;
          str_nx.rd_en = 1'b1;
          rd_addr_nx   = LAST_ADDR;
        end
      end
      S_PRE: begin
        state_nx       = S_RUN;
        cnt_ld         = 1'b1;
        str_nx.busy    = 1'b1;
        str_nx.rd_en   = 1'b1;
        str_nx.prev_ld = 1'b1;
        rd_addr_nx     = '0;
      end
      S_RUN: begin
        cnt_en         = 1'b1;
        str_nx.busy    = 1'b1;
        str_nx.prev_ld = 1'b1;
        str_nx.wr_en   = 1'b1;
        wr_addr_nx     = z[ADDR_W-1:0];
        if (z_last_c) begin
          state_nx = S_DRAIN;
        end else begin
          str_nx.rd_en = 1'b1;
          rd_addr_nx   = ADDR_W'(z + CNT_W'(1));
        end
      end
      S_DRAIN: begin
        state_nx    = S_DONE;
        str_nx.done = 1'b1;
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_clr  = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      prev_ld <= 1'b0;
      wr_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
    end else begin
      busy    <= str_nx.busy;
      done    <= str_nx.done;
      rd_en   <= str_nx.rd_en;
      prev_ld <= str_nx.prev_ld;
      wr_en   <= str_nx.wr_en;
      rd_addr <= rd_addr_nx;
      wr_addr <= wr_addr_nx;
    end
  end

endmodule

// File: tb/tb_colparity_ctrl.sv
// Self-checking bench for colparity_ctrl: 64-slice and 4-slice instances against a phase model.
module tb_colparity_ctrl;
  import colparity_pkg::*;

  localparam int SA = 64;
  localparam int SB = 4;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       prev_ld;
    logic       wr_en;
    logic [7:0] rd_addr;
    logic [7:0] wr_addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic       busy_a, done_a, rd_en_a, prev_ld_a, wr_en_a;
  logic [5:0] rd_addr_a, wr_addr_a;
  logic       busy_b, done_b, rd_en_b, prev_ld_b, wr_en_b;
  logic [1:0] rd_addr_b, wr_addr_b;

  int checks = 0;
  int errors = 0;

  // Behavioural phase model: k counts cycles since the accepting edge (1 = preload).
  bit act_a = 0, act_b = 0;
  int k_a = 0, k_b = 0;

  int q_rd_a[$], q_wr_a[$], q_rd_b[$], q_wr_b[$];
  int n_prev_a = 0;

  // Golden datapath for the 64-slice instance.
  logic [24:0] mem_a [SA];
  logic [24:0] rdata_a;
  logic [4:0]  prev_a;
  logic [4:0]  res_a [SA];

  always #5 clk = ~clk;

  colparity_ctrl #(.SLICES(SA), .ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .prev_ld(prev_ld_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a)
  );

  colparity_ctrl #(.SLICES(SB), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .prev_ld(prev_ld_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b)
  );

  function automatic logic [4:0] colpar(input logic [24:0] s);
    logic [4:0] c = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        c[x] = c[x] ^ s[x + 5 * y];
    return c;
  endfunction

  function automatic logic [4:0] theta_d(input logic [4:0] cur, input logic [4:0] prv);
    logic [4:0] d;
    for (int x = 0; x < 5; x++) d[x] = cur[(x + 4) % 5] ^ prv[(x + 1) % 5];
    return d;
  endfunction

  function automatic obs_t expect_out(input int s, input int k, input bit act);
    obs_t o = '0;
    int   z;
    if (!act) return o;
    if (k == 1) begin
      o.busy = 1; o.rd_en = 1; o.rd_addr = 8'(s - 1);
    end else if (k <= s + 1) begin
      z = k - 2;
      o.busy = 1; o.rd_en = 1; o.rd_addr = 8'(z); o.prev_ld = 1;
      if (z > 0) begin
        o.wr_en = 1; o.wr_addr = 8'(z - int'(RD_LAT));
      end
    end else if (k == s + 2) begin
      o.busy = 1; o.prev_ld = 1; o.wr_en = 1; o.wr_addr = 8'(s - 1);
    end else if (k == s + 3) begin
      o.done = 1;
    end
    return o;
  endfunction

  function automatic obs_t pack(input logic b, input logic d, input logic re, input logic [7:0] ra,
                                input logic pl, input logic we, input logic [7:0] wa);
    obs_t o;
    o.busy = b; o.done = d; o.rd_en = re; o.prev_ld = pl; o.wr_en = we;
    o.rd_addr = re ? ra : 8'd0;
    o.wr_addr = we ? wa : 8'd0;
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_a <= 0; k_a <= 0; act_b <= 0; k_b <= 0;
    end else begin
      if (act_a) begin
        if (k_a == SA + 3) act_a <= 0; else k_a <= k_a + 1;
      end else if (start_a) begin
        act_a <= 1; k_a <= 1;
      end
      if (act_b) begin
        if (k_b == SB + 3) act_b <= 0; else k_b <= k_b + 1;
      end else if (start_b) begin
        act_b <= 1; k_b <= 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= mem_a[rd_addr_a];
    if (prev_ld_a) prev_a <= colpar(rdata_a);
    if (wr_en_a) res_a[wr_addr_a] <= theta_d(colpar(rdata_a), prev_a);
  end

  // Per-cycle compare plus strobe capture, sampled mid-cycle.
  obs_t ob_a, ex_a, ob_b, ex_b;
  always @(negedge clk) begin
    ob_a = pack(busy_a, done_a, rd_en_a, 8'(rd_addr_a), prev_ld_a, wr_en_a, 8'(wr_addr_a));
    ex_a = expect_out(SA, k_a, act_a);
    ob_b = pack(busy_b, done_b, rd_en_b, 8'(rd_addr_b), prev_ld_b, wr_en_b, 8'(wr_addr_b));
    ex_b = expect_out(SB, k_b, act_b);
    checks += 2;
    if (ob_a !== ex_a) begin
      errors++;
      $display("FAIL trace_a t=%0t k=%0d got %h exp %h", $time, k_a, ob_a, ex_a);
    end
    if (ob_b !== ex_b) begin
      errors++;
      $display("FAIL trace_b t=%0t k=%0d got %h exp %h", $time, k_b, ob_b, ex_b);
    end
    if (!rst) begin
      if (rd_en_a) q_rd_a.push_back(int'(rd_addr_a));
      if (wr_en_a) q_wr_a.push_back(int'(wr_addr_a));
      if (prev_ld_a) n_prev_a++;
      if (rd_en_b) q_rd_b.push_back(int'(rd_addr_b));
      if (wr_en_b) q_wr_b.push_back(int'(wr_addr_b));
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic clear_caps();
    q_rd_a.delete(); q_wr_a.delete(); q_rd_b.delete(); q_wr_b.delete();
    n_prev_a = 0;
  endtask

  // Pulse start on one instance and count cycles from the accepting edge to done.
  task automatic run_one(input bit which, input int budget, output int cyc);
    bit seen = 0;
    cyc = 0;
    @(negedge clk);
    if (which) start_b = 1; else start_a = 1;
    while (cyc < budget && !seen) begin
      @(posedge clk); #1;
      cyc++;
      start_a = 0; start_b = 0;
      seen = which ? done_b : done_a;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL done_timeout which=%0d got none exp done within %0d", which, budget);
    end
  endtask

  task automatic load_random_state();
    for (int z = 0; z < SA; z++) begin
      mem_a[z] = 25'($urandom);
      res_a[z] = 'x;
    end
  endtask

  task automatic check_result_ram();
    logic [4:0] ref_d;
    for (int z = 0; z < SA; z++) begin
      ref_d = theta_d(colpar(mem_a[z]), colpar(mem_a[(z + SA - 1) % SA]));
      checks++;
      if (res_a[z] !== ref_d) begin
        errors++;
        $display("FAIL result_z%0d got %h exp %h", z, res_a[z], ref_d);
      end
    end
  endtask

  task automatic check_run_a(input string tag, input int cyc);
    chk({tag, "_latency"}, cyc, 67);
    chk({tag, "_rd_count"}, q_rd_a.size(), 65);
    chk({tag, "_prev_count"}, n_prev_a, 65);
    chk({tag, "_wr_count"}, q_wr_a.size(), 64);
    if (q_rd_a.size() == 65) begin
      chk({tag, "_rd_first"}, q_rd_a[0], 63);
      chk({tag, "_rd_second"}, q_rd_a[1], 0);
      chk({tag, "_rd_last"}, q_rd_a[64], 63);
    end
    for (int i = 0; i < q_wr_a.size(); i++) chk({tag, "_wr_order"}, q_wr_a[i], i);
  endtask

  initial begin
    int cyc;
    int dt[$];
    int exp_rd_b[5];
    int exp_wr_b[4];
    int t;
    exp_rd_b = '{3, 0, 1, 2, 3};
    exp_wr_b = '{0, 1, 2, 3};

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_a", int'({busy_a, done_a, rd_en_a, prev_ld_a, wr_en_a}), 0);
    chk("reset_addr_a", int'({rd_addr_a, wr_addr_a}), 0);
    chk("reset_outs_b", int'({busy_b, done_b, rd_en_b, prev_ld_b, wr_en_b, rd_addr_b, wr_addr_b}), 0);
    @(negedge clk); rst = 0;
    clear_caps();
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_reads", q_rd_a.size() + q_rd_b.size(), 0);
    chk("idle_no_writes", q_wr_a.size() + q_wr_b.size(), 0);

    // Full 64-slice run with golden datapath.
    load_random_state();
    clear_caps();
    run_one(0, 200, cyc);
    check_run_a("run64", cyc);
    check_result_ram();

    // 4-slice instance, full address range.
    repeat (3) @(posedge clk);
    clear_caps();
    run_one(1, 40, cyc);
    chk("run4_latency", cyc, 7);
    chk("run4_rd_count", q_rd_b.size(), 5);
    chk("run4_wr_count", q_wr_b.size(), 4);
    for (int i = 0; i < 5 && i < q_rd_b.size(); i++) chk("run4_rd_order", q_rd_b[i], exp_rd_b[i]);
    for (int i = 0; i < 4 && i < q_wr_b.size(); i++) chk("run4_wr_order", q_wr_b[i], exp_wr_b[i]);

    // Randomized start traffic on both instances.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start_a = ($urandom_range(0, 19) == 0);
      start_b = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); start_a = 0; start_b = 0;
    repeat (80) @(posedge clk);

    // start held high: back-to-back runs.
    @(negedge clk); start_a = 1;
    t = 0;
    while (t < 300 && dt.size() < 2) begin
      @(posedge clk); #1; t++;
      if (done_a) dt.push_back(t);
    end
    start_a = 0;
    chk("b2b_done_count", dt.size(), 2);
    if (dt.size() == 2) begin
      chk("b2b_first_done", dt[0], 67);
      chk("b2b_period", dt[1] - dt[0], 68);
    end
    repeat (5) @(posedge clk);

    // Asynchronous reset mid-run at z=30.
    @(negedge clk); start_a = 1;
    t = 0;
    while (t < 100 && !(act_a && k_a == 32)) begin
      @(posedge clk); #1; t++;
      start_a = 0;
    end
    chk("midrun_rd_addr", int'(rd_addr_a), 30);
    #1 rst = 1;
    #1;
    chk("async_rst_outs", int'({busy_a, done_a, rd_en_a, prev_ld_a, wr_en_a}), 0);
    chk("async_rst_addr", int'({rd_addr_a, wr_addr_a}), 0);
    clear_caps();
    @(posedge clk); @(posedge clk); #3 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_quiet", q_rd_a.size() + q_wr_a.size() + n_prev_a, 0);

    load_random_state();
    clear_caps();
    run_one(0, 200, cyc);
    check_run_a("rerun64", cyc);
    check_result_ram();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
